axi4_lite_read_regbank: RTL

AXI4_LITE_READ_REGBANK -- requirements
Module: axi4_lite_read_regbank

---
 rtl/axi4_lite_read_regbank_if.sv | 35 +++
 rtl/axi4_lite_read_regbank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axi4_lite_read_regbank_if.sv
// AXI4-Lite read channel bundle (AR + R) between a read master and the register bank.
// No logic of its own; latency and backpressure are defined by the attached slave.
// Signal suffixes are named from the slave's point of view (_i into the bank, _o out of it).
interface axi4_lite_read_regbank_if #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    logic [ADDRESS_SIZE-1:0] read_address_i;
    logic                    read_address_valid_i;
    logic                    read_address_ready_o;
    logic [DATA_SIZE-1:0]    read_data_o;
    logic [1:0]              read_data_response_o;
    logic                    read_data_valid_o;
    logic                    read_data_ready_i;

    modport master (
        output read_address_i,
        output read_address_valid_i,
        output read_data_ready_i,
        input  read_address_ready_o,
        input  read_data_o,
        input  read_data_response_o,
        input  read_data_valid_o
    );

    modport slave (
        input  read_address_i,
        input  read_address_valid_i,
        input  read_data_ready_i,
        output read_address_ready_o,
        output read_data_o,
        output read_data_response_o,
        output read_data_valid_o
    );
endinterface

// File: rtl/axi4_lite_read_regbank.sv
// AXI4-Lite read-only register bank: decodes AR addresses into a flat register vector.
// Latency: response valid one cycle after the AR handshake when the response FIFO is empty.
// Backpressure: 2-entry response FIFO; AR ready drops while both entries are occupied.
// Optional: define AXI4_LITE_READ_REGBANK_ERR_COUNT_EN to build the saturating SLVERR counter.
// DATA_SIZE must be 32 or 64; REG_COUNT must be at least 1.
module axi4_lite_read_regbank #(
    parameter int                    ADDRESS_SIZE = 32,
    parameter int                    DATA_SIZE    = 32,
    parameter int                    REG_COUNT    = 8,
    parameter logic [ADDRESS_SIZE-1:0] BASE_ADDRESS = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_clk_ni,
    axi4_lite_read_regbank_if.slave        bus,
    input  logic [REG_COUNT*DATA_SIZE-1:0] register_data_i,
    output logic [15:0]                    error_count_o
);

    localparam int                      OFS_BITS  = (DATA_SIZE == 64) ? 3 : 2;
    localparam logic [ADDRESS_SIZE-1:0] IDX_LIMIT = ADDRESS_SIZE'(REG_COUNT);
    localparam logic [1:0]              RESP_OKAY   = 2'b00;
    localparam logic [1:0]              RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic [1:0]           resp;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    fifo_state_e             state_q, state_d;
    entry_t                  head_q, tail_q;
    entry_t                  new_entry;
    logic                    ready_q, ready_d;
    logic                    push, pop;
    logic                    load_head_new, load_tail_new, shift_tail;
    logic [ADDRESS_SIZE-1:0] offset;
    logic [ADDRESS_SIZE-1:0] reg_idx;

    assign push = bus.read_address_valid_i && ready_q;
    assign pop  = (state_q != EMPTY) && bus.read_data_ready_i;

    // Address decode; the subtraction wraps so addresses below the base land far out of range.
    always_comb begin
        offset    = bus.read_address_i - BASE_ADDRESS;
        reg_idx   = offset >> OFS_BITS;
        new_entry = '0;
        new_entry.resp = RESP_SLVERR;
        if ((offset[OFS_BITS-1:0] == '0) && (reg_idx < IDX_LIMIT)) begin
            new_entry.resp = RESP_OKAY;
            for (int k = 0; k < REG_COUNT; k++) begin
                if (reg_idx == ADDRESS_SIZE'(k)) begin
                    new_entry.data = register_data_i[k*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    // FIFO occupancy register.
    always_ff @(posedge clk_i) begin
        if (!rst_clk_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO next state and entry load controls; head is always the oldest response.
    always_comb begin
        state_d       = state_q;
        load_head_new = 1'b0;
        load_tail_new = 1'b0;
        shift_tail    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d       = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    state_d       = FULL;
                    load_tail_new = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // AR ready is low here, so only a pop can happen.
                if (pop) begin
                    state_d    = ONE;
                    shift_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    // Response storage and registered AR ready.
    always_ff @(posedge clk_i) begin
        if (!rst_clk_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            if (load_head_new) begin
                head_q <= new_entry;
            end else if (shift_tail) begin
                head_q <= tail_q;
            end
            if (load_tail_new) begin
                tail_q <= new_entry;
            end
        end
    end

    assign bus.read_address_ready_o = ready_q;
    assign bus.read_data_valid_o    = (state_q != EMPTY);
    assign bus.read_data_o          = head_q.data;
    assign bus.read_data_response_o = head_q.resp;

`ifdef AXI4_LITE_READ_REGBANK_ERR_COUNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count SLVERR responses as they are handed over, sticking at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (pop && (head_q.resp == RESP_SLVERR) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_clk_ni) begin
            err_cnt_q <= 16'h0000;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign error_count_o = err_cnt_q;
`else
    assign error_count_o = 16'h0000;
`endif

endmodule
